// File: rtl/wave_step_counter.sv
// ---------------------------------------------------------------------------
// wave_step_counter
//
// Phase/step counter feeding the waveform lookup and shaping stages. Each
// enabled cycle the count moves by a (clamped) step according to one of four
// run modes: wrap-up, wrap-down, bounce (triangle) and saturate-up. A
// synchronous load overrides stepping, and a one-cycle wrap pulse marks counts
// that came out of a boundary event. The direction flag only matters in
// bounce mode but is retained across mode changes.
//
// Optional build macro: WAVE_STEP_COUNTER_SYNC_EN
//   When defined, adds sync_i, a hard oscillator sync that has the highest
//   priority and forces the count back to reset_val_p with a wrap pulse.
//
// Parameters:
//   max_val_p   - largest count value (count range 0..max_val_p), >= 1
//   width_p     - width of count, step and load value
//   reset_val_p - count value after reset, <= max_val_p
//
// Ports:
//   clk_i      - clock, all state updates on the rising edge
//   reset_i    - asynchronous active-high reset
//   sync_i     - hard sync (only with WAVE_STEP_COUNTER_SYNC_EN)
//   en_i       - advance the count by step_i this cycle
//   step_i     - step size, clamped to max_val_p, 0 holds the count
//   mode_i     - 00 wrap-up, 01 wrap-down, 10 bounce, 11 saturate-up
//   load_v_i   - load load_val_i into the count (overrides en_i)
//   load_val_i - load value, clamped to max_val_p
//   count_no   - combinational next count (what count_o takes next edge)
//   count_o    - registered count
//   dir_o      - registered direction, 0 = up, 1 = down
//   wrap_o     - registered boundary pulse for the current count_o
// ---------------------------------------------------------------------------
module wave_step_counter #(
   parameter int max_val_p   = 15,
   parameter int width_p     = $clog2(max_val_p + 1),
   parameter int reset_val_p = 0
) (
   input  logic               clk_i,
   input  logic               reset_i,
`ifdef WAVE_STEP_COUNTER_SYNC_EN
   input  logic               sync_i,
`endif
   input  logic               en_i,
   input  logic [width_p-1:0] step_i,
   input  logic [1:0]         mode_i,
   input  logic               load_v_i,
   input  logic [width_p-1:0] load_val_i,
   output logic [width_p-1:0] count_no,
   output logic [width_p-1:0] count_o,
   output logic               dir_o,
   output logic               wrap_o
);

   typedef enum logic [1:0] {
      MODE_WRAP_UP   = 2'b00,
      MODE_WRAP_DOWN = 2'b01,
      MODE_BOUNCE    = 2'b10,
      MODE_SATURATE  = 2'b11
   } mode_t;

   // All arithmetic is done one bit wider than the count so that sums,
   // the full period (max+1) and the bounce reflection point (2*max) fit.
   localparam logic [width_p:0]   max_ext     = (width_p + 1)'(max_val_p);
   localparam logic [width_p:0]   span_ext    = (width_p + 1)'(max_val_p + 1);
   localparam logic [width_p:0]   twice_max   = (width_p + 1)'(2 * max_val_p);
   localparam logic [width_p-1:0] reset_count = width_p'(reset_val_p);

   mode_t              mode;
   logic [width_p:0]   step_ext;
   logic [width_p:0]   step_sat;
   logic [width_p:0]   count_ext;
   logic [width_p:0]   sum_ext;
   logic [width_p:0]   load_ext;
   logic [width_p-1:0] next_count;
   logic               next_dir;
   logic               next_wrap;

   assign mode = mode_t'(mode_i);

   // Next-state logic. Priority is sync (optional) > load > enable > hold.
   // Holding clears the wrap pulse but keeps count and direction. Bounce
   // mode reflects any overshoot off the end points; landing exactly on an
   // end point turns around without signalling a wrap.
   always_comb begin
      step_ext   = {1'b0, step_i};
      step_sat   = (step_ext > max_ext) ? max_ext : step_ext;
      count_ext  = {1'b0, count_o};
      sum_ext    = count_ext + step_sat;
      load_ext   = {1'b0, load_val_i};
      next_count = count_o;
      next_dir   = dir_o;
      next_wrap  = 1'b0;

`ifdef WAVE_STEP_COUNTER_SYNC_EN
      if (sync_i) begin
         next_count = reset_count;
         next_dir   = 1'b0;
         next_wrap  = 1'b1;
      end else
`endif
      if (load_v_i) begin
         next_count = (load_ext > max_ext) ? width_p'(max_ext) : load_val_i;
         next_dir   = 1'b0;
         next_wrap  = 1'b0;
      end else if (en_i) begin
         case (mode)
            MODE_WRAP_UP: begin
               if (sum_ext > max_ext) begin
                  next_count = width_p'(sum_ext - span_ext);
                  next_wrap  = 1'b1;
               end else begin
                  next_count = width_p'(sum_ext);
               end
            end
            MODE_WRAP_DOWN: begin
               if (step_sat > count_ext) begin
                  next_count = width_p'(count_ext + span_ext - step_sat);
                  next_wrap  = 1'b1;
               end else begin
                  next_count = width_p'(count_ext - step_sat);
               end
            end
            MODE_BOUNCE: begin
               if (!dir_o) begin
                  if (sum_ext > max_ext) begin
                     next_count = width_p'(twice_max - sum_ext);
                     next_dir   = 1'b1;
                     next_wrap  = 1'b1;
                  end else if (sum_ext == max_ext) begin
                     next_count = width_p'(max_ext);
                     next_dir   = 1'b1;
                  end else begin
                     next_count = width_p'(sum_ext);
                  end
               end else begin
                  if (step_sat > count_ext) begin
                     next_count = width_p'(step_sat - count_ext);
                     next_dir   = 1'b0;
                     next_wrap  = 1'b1;
                  end else if (step_sat == count_ext) begin
                     next_count = '0;
                     next_dir   = 1'b0;
                  end else begin
                     next_count = width_p'(count_ext - step_sat);
                  end
               end
            end
            MODE_SATURATE: begin
               if (sum_ext >= max_ext) begin
                  next_count = width_p'(max_ext);
                  next_wrap  = (count_ext < max_ext);
               end else begin
                  next_count = width_p'(sum_ext);
               end
            end
            default: begin
               next_count = count_o;
            end
         endcase
      end
   end

   assign count_no = next_count;

   // State register; reset clears any pending wrap pulse immediately.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_o <= reset_count;
         dir_o   <= 1'b0;
         wrap_o  <= 1'b0;
      end else begin
         count_o <= next_count;
         dir_o   <= next_dir;
         wrap_o  <= next_wrap;
      end
   end

endmodule

// File: tb/tb_wave_step_counter.sv
// ---------------------------------------------------------------------------
// tb_wave_step_counter
//
// Bench for wave_step_counter with default parameters (max 15, width 4).
// A behavioural model computes the expected count, direction and wrap pulse
// with plain integer arithmetic; a compare process checks the DUT against it
// on every falling edge, and directed sequences pin exact literal values.
// ---------------------------------------------------------------------------
module tb_wave_step_counter;

   localparam int MAX   = 15;
   localparam int WIDTH = 4;

   typedef struct packed {
      int   count;
      logic dir;
      logic wrap;
   } model_t;

   logic             clk;
   logic             reset;
   logic             sync_r;
   logic             en;
   logic [WIDTH-1:0] step;
   logic [1:0]       mode;
   logic             load_v;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count_no;
   logic [WIDTH-1:0] count_o;
   logic             dir_o;
   logic             wrap_o;

   int     tests_run    = 0;
   int     tests_failed = 0;
   logic   check_en     = 1'b0;
   model_t m_state;

   wave_step_counter #(
      .max_val_p  (MAX),
      .width_p    (WIDTH),
      .reset_val_p(0)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset),
`ifdef WAVE_STEP_COUNTER_SYNC_EN
      .sync_i    (sync_r),
`endif
      .en_i      (en),
      .step_i    (step),
      .mode_i    (mode),
      .load_v_i  (load_v),
      .load_val_i(load_val),
      .count_no  (count_no),
      .count_o   (count_o),
      .dir_o     (dir_o),
      .wrap_o    (wrap_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference behaviour: what the counter should do next given its current
   // count/direction and this cycle's inputs.
   function automatic model_t model_next(input int c, input logic d,
                                         input logic sy, input logic ld,
                                         input int lv, input logic e,
                                         input int st, input int md);
      model_t r;
      int s;
      int t;
      s      = (st > MAX) ? MAX : st;
      r.count = c;
      r.dir   = d;
      r.wrap  = 1'b0;
      if (sy) begin
         r.count = 0;
         r.dir   = 1'b0;
         r.wrap  = 1'b1;
      end else if (ld) begin
         r.count = (lv > MAX) ? MAX : lv;
         r.dir   = 1'b0;
      end else if (e) begin
         case (md)
            0: begin
               r.count = (c + s) % (MAX + 1);
               r.wrap  = (c + s) > MAX;
            end
            1: begin
               r.count = (c - s + MAX + 1) % (MAX + 1);
               r.wrap  = s > c;
            end
            2: begin
               if (!d) begin
                  t = c + s;
                  if (t > MAX) begin
                     r.count = 2 * MAX - t;
                     r.dir   = 1'b1;
                     r.wrap  = 1'b1;
                  end else begin
                     r.count = t;
                     if (t == MAX) r.dir = 1'b1;
                  end
               end else begin
                  t = c - s;
                  if (t < 0) begin
                     r.count = -t;
                     r.dir   = 1'b0;
                     r.wrap  = 1'b1;
                  end else begin
                     r.count = t;
                     if (t == 0) r.dir = 1'b0;
                  end
               end
            end
            default: begin
               r.count = (c + s > MAX) ? MAX : c + s;
               r.wrap  = (c < MAX) && (r.count == MAX);
            end
         endcase
      end
      return r;
   endfunction

   // Model state follows the same clock and asynchronous reset as the DUT.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_state <= '{count: 0, dir: 1'b0, wrap: 1'b0};
      end else begin
         m_state <= model_next(m_state.count, m_state.dir, sync_r, load_v,
                               int'(load_val), en, int'(step), int'(mode));
      end
   end

   // Compare registered outputs and the combinational next count against
   // the model on every falling edge.
   always @(negedge clk) begin
      if (check_en) begin
         model_t exp_next;
         exp_next = model_next(m_state.count, m_state.dir, sync_r, load_v,
                               int'(load_val), en, int'(step), int'(mode));
         tests_run++;
         if (count_o !== WIDTH'(m_state.count) || dir_o !== m_state.dir ||
             wrap_o !== m_state.wrap || count_no !== WIDTH'(exp_next.count)) begin
            tests_failed++;
            $display("[TB] FAIL model_cmp t=%0t got count_o=%0d dir_o=%0d wrap_o=%0d count_no=%0d expected %0d %0d %0d %0d",
                     $time, count_o, dir_o, wrap_o, count_no,
                     m_state.count, m_state.dir, m_state.wrap, exp_next.count);
         end
      end
   end

   // Drive one cycle of inputs, then wait until just after the next edge.
   task automatic applyStimulus(input logic e, input int st, input int md,
                                input logic ld, input int lv);
      en       = e;
      step     = WIDTH'(st);
      mode     = 2'(md);
      load_v   = ld;
      load_val = WIDTH'(lv);
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string name, input int exp_count,
                              input logic exp_dir, input logic exp_wrap);
      tests_run++;
      if (count_o !== WIDTH'(exp_count) || dir_o !== exp_dir || wrap_o !== exp_wrap) begin
         tests_failed++;
         $display("[TB] FAIL %s got count=%0d dir=%0d wrap=%0d expected count=%0d dir=%0d wrap=%0d",
                  name, count_o, dir_o, wrap_o, exp_count, exp_dir, exp_wrap);
      end
   endtask

   initial begin
      int up_c[6];
      int dn_c[4];
      logic dn_w[4];
      int bn_c[6];
      logic bn_d[6];
      logic bn_w[6];

      up_c = '{3, 6, 9, 12, 15, 2};
      dn_c = '{13, 8, 3, 14};
      dn_w = '{1'b1, 1'b0, 1'b0, 1'b1};
      bn_c = '{14, 10, 6, 2, 2, 6};
      bn_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      bn_w = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      reset    = 1'b0;
      sync_r   = 1'b0;
      en       = 1'b0;
      step     = '0;
      mode     = 2'b00;
      load_v   = 1'b0;
      load_val = '0;
      #1 reset = 1'b1;
      #1 check_en = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      checkOutput("reset_init", 0, 1'b0, 1'b0);

      // Run a little, then reset asynchronously mid-cycle with en held.
      applyStimulus(1'b1, 3, 0, 1'b0, 0);
      applyStimulus(1'b1, 3, 0, 1'b0, 0);
      checkOutput("pre_reset", 6, 1'b0, 1'b0);
      #1 reset = 1'b1;
      #1 checkOutput("reset_async", 0, 1'b0, 1'b0);
      @(posedge clk);
      #2 checkOutput("reset_held_1", 0, 1'b0, 1'b0);
      @(posedge clk);
      #2 checkOutput("reset_held_2", 0, 1'b0, 1'b0);
      #1 reset = 1'b0;

      // Wrap-up from 0 with step 3.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 3, 0, 1'b0, 0);
         checkOutput("wrap_up", up_c[i], 1'b0, (i == 5));
      end

      // Wrap-down from 2 with step 5.
      applyStimulus(1'b0, 5, 1, 1'b1, 2);
      checkOutput("load_2", 2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5, 1, 1'b0, 0);
         checkOutput("wrap_down", dn_c[i], 1'b0, dn_w[i]);
      end

      // Bounce from 12 with step 4.
      applyStimulus(1'b0, 4, 2, 1'b1, 12);
      checkOutput("load_12", 12, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 4, 2, 1'b0, 0);
         checkOutput("bounce", bn_c[i], bn_d[i], bn_w[i]);
      end

      // Saturate, load-over-enable and step clamp.
      applyStimulus(1'b0, 7, 3, 1'b1, 10);
      checkOutput("load_10", 10, 1'b0, 1'b0);
      applyStimulus(1'b1, 7, 3, 1'b0, 0);
      checkOutput("sat_hit", 15, 1'b0, 1'b1);
      applyStimulus(1'b1, 7, 3, 1'b0, 0);
      checkOutput("sat_hold", 15, 1'b0, 1'b0);
      applyStimulus(1'b1, 7, 3, 1'b1, 15);
      checkOutput("load_beats_en", 15, 1'b0, 1'b0);
      applyStimulus(1'b1, 15, 0, 1'b0, 0);
      checkOutput("step_15_wrap", 14, 1'b0, 1'b1);

      // Priority and hold.
      applyStimulus(1'b1, 3, 0, 1'b1, 5);
      checkOutput("prio_load", 5, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 3, 0, 1'b0, 0);
         checkOutput("hold", 5, 1'b0, 1'b0);
      end

      // Step 0 in wrap-up keeps the count and clears wrap.
      applyStimulus(1'b1, 0, 0, 1'b0, 0);
      checkOutput("step_zero", 5, 1'b0, 1'b0);

`ifdef WAVE_STEP_COUNTER_SYNC_EN
      sync_r = 1'b1;
      applyStimulus(1'b1, 3, 0, 1'b1, 5);
      sync_r = 1'b0;
      checkOutput("sync_beats_load", 0, 1'b0, 1'b1);
`endif

      // Random mixed traffic, checked by the model compare process.
      for (int i = 0; i < 400; i++) begin
`ifdef WAVE_STEP_COUNTER_SYNC_EN
         sync_r = ($urandom_range(0, 19) == 0);
`endif
         applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 15),
                       $urandom_range(0, 3), $urandom_range(0, 9) == 0,
                       $urandom_range(0, 15));
      end
      sync_r = 1'b0;

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/wave_step_counter.md
Name: wave_step_counter

Overview:
Parametrised phase/step counter for waveform generation. It is the successor to the basic up/down wave counter.
- Advances by a programmable step per enable.
- Four run modes: wrap-up, wrap-down, bounce (triangle) and saturate.
- Supports synchronous load, a registered boundary pulse and a direction flag.
- Sits between the note/pitch control logic and the waveform lookup/shaping stages.

Parameters:
- max_val_p, 15: largest count value; count range is 0..max_val_p inclusive; must be >= 1.
- width_p, $clog2(max_val_p+1): count, step and load width.
- reset_val_p, 0: count value after reset; must be <= max_val_p.

Ports:
- clk_i, input, 1: clock; all state updates on rising edge.
- reset_i, input, 1: reset, asynchronous, active-high.
- en_i, input, 1: advance the count by step_i this cycle.
- step_i, input, width_p: step size; values above max_val_p are clamped to max_val_p; 0 holds the count.
- mode_i, input, 2: run mode. 00 wrap-up, 01 wrap-down, 10 bounce, 11 saturate-up.
- load_v_i, input, 1: load load_val_i into the count.
- load_val_i, input, width_p: load value; clamped to max_val_p.
- count_no, output, width_p: combinational next count (value count_o will take at the next edge).
- count_o, output, width_p: registered count.
- dir_o, output, 1: registered direction; 0 = up, 1 = down. Meaningful in bounce mode only.
- wrap_o, output, 1: registered one-cycle pulse marking that the current count_o resulted from a boundary event.

Behaviour:
- Reset (async assert; deassert synchronised externally):
  - count_o = reset_val_p, dir_o = 0, wrap_o = 0.
- Arithmetic:
  - Internal sums are width_p+1 bits; s = clamped step.
  - No overflow is possible for any legal input.
- Priority per cycle: load_v_i > en_i > hold.
- Load:
  - count <= min(load_val_i, max_val_p); dir <= 0; wrap <= 0.
  - en_i is ignored in the same cycle.
- Hold (no load, no en):
  - count and dir unchanged; wrap <= 0.
- Wrap-up (00):
  - If c+s > max: next = c+s-(max+1), wrap <= 1.
  - Else: next = c+s.
- Wrap-down (01):
  - If s > c: next = c+(max+1)-s, wrap <= 1.
  - Else: next = c-s.
- Bounce (10), dir=0:
  - If c+s > max: next = 2*max-c-s, dir <= 1, wrap <= 1.
  - If c+s == max: next = max, dir <= 1, wrap <= 0.
  - Else: next = c+s.
- Bounce (10), dir=1:
  - If s > c: next = s-c, dir <= 0, wrap <= 1.
  - If s == c: next = 0, dir <= 0, wrap <= 0.
  - Else: next = c-s.
- Saturate-up (11):
  - next = min(c+s, max).
  - wrap <= 1 only when c < max and next == max.
  - At max: holds, wrap <= 0.
- Direction outside bounce:
  - dir is unchanged in modes 00, 01 and 11.
  - Re-entering bounce resumes with the retained dir.
- Mode changes:
  - mode_i is sampled every cycle and takes effect immediately on that cycle's enabled update.
  - No pipeline state.
- Step 0:
  - count unchanged, wrap <= 0.
- Timing:
  - count_no reflects the same priority logic combinationally.
  - count_o lags count_no by exactly 1 cycle.
  - wrap_o and dir_o change in the same cycle as count_o.
- Reset mid-operation:
  - Immediate return to reset values regardless of en/load.
  - A pending wrap pulse is cleared.

Optional Feature:
WAVE_STEP_COUNTER_SYNC_EN

With the macro defined:
- Adds input sync_i (1 bit), a hard oscillator sync.
- Priority: sync_i > load_v_i > en_i.
- sync_i forces count <= reset_val_p, dir <= 0, wrap <= 1 next cycle.
- count_no = reset_val_p while sync_i = 1.

Without the macro:
- The sync_i port does not exist.
- Behaviour is exactly as above.

Test Plan:
All tests use defaults (max 15, width 4).
- Reset: assert reset_i asynchronously mid-cycle with en_i=1 → count_o=0, dir_o=0, wrap_o=0 immediately; state stays there while reset is held.
- Wrap-up: mode 00, step 3, en held from 0 → count_o sequence 0,3,6,9,12,15,2; wrap_o=1 only on the cycle count_o=2.
- Wrap-down: load 2, then mode 01, step 5, en → 13 (wrap_o=1), 8, 3, 14 (wrap_o=1).
- Bounce: load 12, mode 10, step 4 → sequence:
  - 14 (dir_o=1, wrap_o=1)
  - 10, 6
  - 2
  - 2 (s-c=4-2; dir_o=0, wrap_o=1)
  - 6
- Saturate and clamps: mode 11, load 10, step 7 → 15 (wrap_o=1), then holds 15 (wrap_o=0). Then load_val_i=15 with load_v_i and en_i both 1 → count_o=15, dir_o=0. Then step_i=15 in mode 00 → count=14.
- Priority/hold: load_v_i=1 with load_val_i=5 and en_i=1, step 3 → count_o=5. en_i=0 for 3 cycles → count_o stays 5, wrap_o=0. (With WAVE_STEP_COUNTER_SYNC_EN: sync_i=1 alongside load → count_o=0, wrap_o=1.)
